// File: rtl/i2lbs_window_scheduler.sv
// i2lbs_window_scheduler: raster pixel intake for the integral-image line buffer,
// offering every complete IW x IH window to the classifier with a valid/ack handshake.
module i2lbs_window_scheduler #(
   parameter int DATA_WIDTH_8        = 8,
   parameter int DATA_WIDTH_16       = 16,
   parameter int INTEGRAL_WIDTH      = 3,
   parameter int INTEGRAL_HEIGHT     = 3,
   parameter int FRAME_CAMERA_WIDTH  = 10,
   parameter int FRAME_CAMERA_HEIGHT = 10
) (
   input  logic                     clk_os,
   input  logic                     reset_os,
   input  logic                     i_frame_start,
   input  logic [DATA_WIDTH_8-1:0]  i_pixel,
   input  logic                     i_pixel_valid,
   output logic                     o_pixel_ready,
   output logic                     o_wen,
   output logic [DATA_WIDTH_8-1:0]  o_pixel,
   output logic                     o_window_valid,
   input  logic                     i_window_ack,
   output logic [DATA_WIDTH_16-1:0] o_window_x,
   output logic [DATA_WIDTH_16-1:0] o_window_y,
   output logic                     o_frame_done,
   output logic                     o_busy
);
   localparam logic [DATA_WIDTH_16-1:0] IW1 = DATA_WIDTH_16'(INTEGRAL_WIDTH - 1);
   localparam logic [DATA_WIDTH_16-1:0] IH1 = DATA_WIDTH_16'(INTEGRAL_HEIGHT - 1);
   localparam logic [DATA_WIDTH_16-1:0] FW1 = DATA_WIDTH_16'(FRAME_CAMERA_WIDTH - 1);
   localparam logic [DATA_WIDTH_16-1:0] FH1 = DATA_WIDTH_16'(FRAME_CAMERA_HEIGHT - 1);

   typedef enum logic [2:0] {IDLE, RUN, WRITE, WAIT_ACK, DONE} state_t;

   state_t                   state_q, state_d;
   logic [DATA_WIDTH_16-1:0] col_q, col_d, row_q, row_d, x_q, x_d, y_q, y_d;
   logic [DATA_WIDTH_8-1:0]  pix_q, pix_d;
   logic                     wen_q, wen_d;
   logic                     accept, qual, last;

   assign accept = i_pixel_valid && state_q == RUN;
   assign qual   = col_q >= IW1 && row_q >= IH1;
   // the bottom-right window is the one whose qualifying pixel was (FW-1, FH-1)
   assign last   = x_q == FW1 - IW1 && y_q == FH1 - IH1;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      x_d     = x_q;
      y_d     = y_q;
      pix_d   = pix_q;
      wen_d   = accept;
      unique case (state_q)
         IDLE: if (i_frame_start) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = '0;
         end
         RUN: if (accept) begin
            pix_d = i_pixel;
            col_d = col_q == FW1 ? '0 : col_q + 1'b1;
            row_d = col_q == FW1 ? row_q + 1'b1 : row_q;
            if (qual) begin
               state_d = WRITE;
               x_d     = col_q - IW1;
               y_d     = row_q - IH1;
            end
         end
         WRITE:    state_d = WAIT_ACK;
         WAIT_ACK: if (i_window_ack) state_d = last ? DONE : RUN;
         DONE: begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_os or negedge reset_os) begin
      if (!reset_os) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         pix_q   <= '0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pix_q   <= pix_d;
         wen_q   <= wen_d;
      end
   end

   assign o_pixel_ready  = state_q == RUN;
   assign o_wen          = wen_q;
   assign o_pixel        = pix_q;
   assign o_window_valid = state_q == WAIT_ACK;
   assign o_window_x     = x_q;
   assign o_window_y     = y_q;
   assign o_frame_done   = state_q == DONE;
   assign o_busy         = state_q != IDLE;
endmodule

// File: tb/tb_i2lbs_window_scheduler.sv
// tb_i2lbs_window_scheduler: random-stimulus bench for a 10x10 and a 3x3 scheduler instance,
// scored against window lists and latency rules derived from pixel index arithmetic.
module tb_i2lbs_window_scheduler;
   logic        clk_os = 1'b0;
   logic        reset_os = 1'b0;
   logic        fs = 1'b0, pv = 1'b0, ack = 1'b0, sel = 1'b0;
   logic [7:0]  pix = '0;
   logic        a_rdy, a_wen, a_wv, a_done, a_busy, b_rdy, b_wen, b_wv, b_done, b_busy;
   logic [7:0]  a_pix, b_pix;
   logic [15:0] a_x, a_y, b_x, b_y;
   logic        rdy, wen, wv, done, busy;
   logic [7:0]  opix;
   logic [15:0] wx, wy;
   int          vectors = 0, miscompares = 0;

   always #5 clk_os = ~clk_os;

   i2lbs_window_scheduler dut_a (
      .clk_os(clk_os), .reset_os(reset_os), .i_frame_start(fs && !sel), .i_pixel(pix),
      .i_pixel_valid(pv), .o_pixel_ready(a_rdy), .o_wen(a_wen), .o_pixel(a_pix),
      .o_window_valid(a_wv), .i_window_ack(ack), .o_window_x(a_x), .o_window_y(a_y),
      .o_frame_done(a_done), .o_busy(a_busy));

   i2lbs_window_scheduler #(.FRAME_CAMERA_WIDTH(3), .FRAME_CAMERA_HEIGHT(3)) dut_b (
      .clk_os(clk_os), .reset_os(reset_os), .i_frame_start(fs && sel), .i_pixel(pix),
      .i_pixel_valid(pv), .o_pixel_ready(b_rdy), .o_wen(b_wen), .o_pixel(b_pix),
      .o_window_valid(b_wv), .i_window_ack(ack), .o_window_x(b_x), .o_window_y(b_y),
      .o_frame_done(b_done), .o_busy(b_busy));

   assign rdy  = sel ? b_rdy  : a_rdy;
   assign wen  = sel ? b_wen  : a_wen;
   assign opix = sel ? b_pix  : a_pix;
   assign wv   = sel ? b_wv   : a_wv;
   assign wx   = sel ? b_x    : a_x;
   assign wy   = sel ? b_y    : a_y;
   assign done = sel ? b_done : a_done;
   assign busy = sel ? b_busy : a_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, {a_rdy, a_wen, a_wv, a_done, a_busy, 3'b0, a_pix, a_x[7:0] | a_y[7:0]}, 0);
      check({tag, "_b"}, {b_rdy, b_wen, b_wv, b_done, b_busy, 3'b0, b_pix, b_x[7:0] | b_y[7:0]}, 0);
      check({tag, "_xy"}, {a_x, a_y} | {b_x, b_y}, 0);
   endtask

   // vmode: 0 back-to-back, 1 every other cycle, 2 random; amode: 0 ack tied high, 1 random delays
   task automatic run_frame(input int vmode, input int amode, input int abort_at);
      int fw = sel ? 3 : 10;
      int ewx[$], ewy[$];
      logic [7:0] pq[$];
      int nwen = 0, nwin = 0, ndone = 0, accepted = 0, hold = 0, dly = 0, k;
      int qual_cyc = -10, ack_cyc = -10, done_cyc = -10, cx = 0, cy = 0;
      bit prev_v = 0, was_last = 0, fin = 0;
      for (int y = 0; y <= fw - 3; y++)
         for (int x = 0; x <= fw - 3; x++) begin
            ewx.push_back(x);
            ewy.push_back(y);
         end
      @(negedge clk_os);
      fs = 1'b1;
      @(negedge clk_os);
      fs = 1'b0;
      check("busy_start", busy, 1);
      check("ready_start", rdy, 1);
      for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
         @(negedge clk_os);
         if (wen) begin
            nwen++;
            if (pq.size() > 0) check("wdata", opix, pq.pop_front());
            else check("extra_wen", wen, 0);
         end
         if (wv) begin
            check("ready_in_wait", rdy, 0);
            check("wen_in_wait", wen, 0);
            if (!prev_v) begin
               if (ewx.size() == 0) check("extra_window", wv, 0);
               else begin
                  cx = ewx[0];
                  cy = ewy[0];
                  check("win_x", wx, cx);
                  check("win_y", wy, cy);
                  check("latency", cyc, qual_cyc + 2);
               end
               hold = 0;
               dly = amode == 0 ? 0 : (cx == 3 && cy == 4) ? 5 : $urandom_range(0, 3);
            end else begin
               check("hold_x", wx, cx);
               check("hold_y", wy, cy);
            end
            hold++;
         end else if (prev_v) check("hold_len", hold, dly + 1);
         if (cyc == ack_cyc + 1 && !was_last) check("ready_after_ack", rdy, 1);
         if (done) begin
            ndone++;
            check("done_timing", cyc, ack_cyc + 1);
            check("done_after_last", was_last, 1);
            done_cyc = cyc;
         end
         if (cyc == done_cyc + 1) begin
            check("done_pulse", done, 0);
            check("idle_busy", busy, 0);
            fin = 1;
         end else if (abort_at > 0 && accepted >= abort_at && wv) begin
            #2 reset_os = 1'b0;
            #1 check_all_zero("async_reset");
            pv = 1'b0; ack = 1'b0; fs = 1'b0;
            @(negedge clk_os);
            reset_os = 1'b1;
            return;
         end else begin
            ack = amode == 0 ? 1'b1 : wv ? hold > dly : $urandom_range(0, 5) == 0;
            if (ack && wv) begin
               void'(ewx.pop_front());
               void'(ewy.pop_front());
               nwin++;
               ack_cyc = cyc;
               was_last = ewx.size() == 0;
            end
            pv = vmode == 0 ? 1'b1 : vmode == 1 ? cyc % 2 == 1 : $urandom_range(0, 1) == 1;
            pix = 8'($urandom);
            fs = amode == 1 && $urandom_range(0, 7) == 0;
            if (pv && rdy) begin
               pq.push_back(pix);
               k = accepted++;
               if (k % fw >= 2 && k / fw >= 2) qual_cyc = cyc;
            end
         end
         prev_v = wv;
      end
      pv = 1'b0; ack = 1'b0; fs = 1'b0;
      if (!fin) check("timeout", 0, 1);
      check("wen_count", nwen, fw * fw);
      check("win_count", nwin, (fw - 2) * (fw - 2));
      check("done_count", ndone, 1);
      check("pending_writes", pq.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk_os);
      check_all_zero("reset");
      reset_os = 1'b1;
      pv = 1'b1;
      ack = 1'b1;
      repeat (4) begin
         @(negedge clk_os);
         check("idle_ready", rdy, 0);
         check("idle_wen", wen, 0);
         check("idle_busy0", busy, 0);
         check("idle_valid", wv, 0);
      end
      pv = 1'b0;
      ack = 1'b0;
      run_frame(0, 0, 0);
      run_frame(1, 1, 0);
      run_frame(2, 1, 50);
      run_frame(0, 1, 0);
      run_frame(2, 1, 0);
      sel = 1'b1;
      run_frame(0, 0, 0);
      run_frame(2, 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
